coproc_sequencer: RTL and testbench
===================================

COPROC_SEQUENCER -- requirements
Module: coproc_sequencer

Interface
REQ-001 The module SHALL provide parameter MEM_LATENCY: default 1, range 1..3, the number of memory read-latency cycles.
REQ-002 The module SHALL provide parameter TIMEOUT_CYCLES: default 255, range 1..255, the execute watchdog limit (used only with SEQ_TIMEOUT_EN).
REQ-003 clock  in  1  the single clock; all sequential logic SHALL be on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request, from the debounced button.
REQ-006 base_addr  in  3  instruction slot, sampled when start is accepted.
REQ-007 mem_addr  out  3  memory address.
REQ-008 mem_we  out  1  memory write enable.
REQ-009 mem_wdata  out  200  memory write data.
REQ-010 mem_rdata  in  224  memory read data: [2:0] opcode, [15:8] tamanho, [215:16] matrix.
REQ-011 opcode  out  3  registered opcode to the execute unit.
REQ-012 tamanho  out  8  registered matrix size to the execute unit.
REQ-013 matrix_a, matrix_b  out  200 each  registered operands.
REQ-014 exec_start  out  1  one-cycle execute request.
REQ-015 exec_done  in  1  execute completion strobe.
REQ-016 exec_result  in  200  execute result; valid in the exec_done cycle.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 error  out  1  sticky fault flag.
REQ-020 state_dbg  out  4  current state encoding, for the LEDs.

Function
REQ-021 The FSM SHALL use these states and encodings: IDLE=0, RD_A=1, LD_A=2, RD_B=3, LD_B=4, EXEC=5, WAIT_EXEC=6, WRITE=7, DONE=8.
REQ-022 IDLE: start=1 SHALL latch base_addr, clear error and go to RD_A; start in any other state SHALL be ignored.
REQ-023 RD_A SHALL drive mem_addr=base and last exactly MEM_LATENCY+1 cycles; mem_rdata SHALL be captured at the edge that leaves the state.
REQ-024 LD_A SHALL register opcode=[2:0], tamanho=[15:8] and matrix_a=[215:16].
REQ-025 From LD_A, an opcode of 7 or a tamanho outside 2..5 SHALL set error and go to DONE; otherwise the FSM SHALL go to RD_B.
REQ-026 RD_B and LD_B SHALL behave as RD_A and LD_A with address base+1 (mod 8), loading only matrix_b.
REQ-027 EXEC SHALL assert exec_start for exactly one cycle, then go to WAIT_EXEC.
REQ-028 WAIT_EXEC SHALL latch exec_result when exec_done=1 and go to WRITE; exec_done in any other state SHALL be ignored.
REQ-029 WRITE SHALL assert mem_we for exactly one cycle with mem_addr=base+2 (mod 8) and mem_wdata equal to the latched result.
REQ-030 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-031 All address arithmetic SHALL be 3-bit and wrap modulo 8.
REQ-032 mem_we SHALL be 0 in every state except WRITE.
REQ-033 Operand registers SHALL hold their values until they are next loaded.

Reset
REQ-034 When reset_n=0, the module SHALL immediately force: state IDLE, and every output, base register, result register and counter to 0.
REQ-035 A reset asserted in any state, including WRITE, SHALL abort the operation with no further memory write.

Configuration
REQ-036 SEQ_TIMEOUT_EN defined: an 8-bit counter SHALL run in WAIT_EXEC; when it reaches TIMEOUT_CYCLES without exec_done, the FSM SHALL set error, skip WRITE and go to DONE.
REQ-037 SEQ_TIMEOUT_EN undefined: WAIT_EXEC SHALL wait indefinitely, and no counter logic SHALL be present.

Verification
REQ-038 MEM_LATENCY=1, base_addr=0, slot0 opcode=1 and tamanho=3, exec_done 4 cycles after exec_start with result 200'h1234 -> exactly one mem_we cycle at addr 2 with wdata 200'h1234, then one done pulse, busy=0, error=0.
REQ-039 base_addr=7 -> reads addr 7 then addr 0, and writes addr 1.
REQ-040 Slot opcode=7, or tamanho=9 -> error=1 and a done pulse, with no exec_start and no mem_we.
REQ-041 start pulse during WAIT_EXEC and exec_done pulse in IDLE -> no state change and no extra memory write.
REQ-042 reset_n=0 in WAIT_EXEC, then exec_done -> busy=0 and mem_we=0 immediately, with no write.
REQ-043 SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=16 and exec_done never asserted -> error=1 after 16 WAIT_EXEC cycles, done pulse, no mem_we; a new start clears error.

Source files
------------

// File: rtl/coproc_sequencer_if.sv
// Memory and execute-unit bus between the coprocessor sequencer (master)
// and the instruction memory / execute unit (slave).
interface coproc_sequencer_if;
    logic [2:0]   mem_addr;
    logic         mem_we;
    logic [199:0] mem_wdata;
    logic [223:0] mem_rdata;
    logic [2:0]   opcode;
    logic [7:0]   tamanho;
    logic [199:0] matrix_a;
    logic [199:0] matrix_b;
    logic         exec_start;
    logic         exec_done;
    logic [199:0] exec_result;

    modport master (
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output opcode, tamanho, matrix_a, matrix_b, exec_start,
        input  exec_done, exec_result
    );

    modport slave (
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  opcode, tamanho, matrix_a, matrix_b, exec_start,
        output exec_done, exec_result
    );
endinterface

// File: rtl/coproc_sequencer.sv
// Fetches two operand slots, runs the execute unit, writes the result back.
// Optional execute watchdog enabled by defining SEQ_TIMEOUT_EN.
module coproc_sequencer #(
    parameter int MEM_LATENCY    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2:0]           base_addr,
    coproc_sequencer_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [3:0]           state_dbg
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD_A      = 4'd1,
        LD_A      = 4'd2,
        RD_B      = 4'd3,
        LD_B      = 4'd4,
        EXEC      = 4'd5,
        WAIT_EXEC = 4'd6,
        WRITE     = 4'd7,
        DONE      = 4'd8
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   base_q, base_d;
    logic [1:0]   lat_q, lat_d;
    logic [2:0]   rd_op_q, rd_op_d;
    logic [7:0]   rd_size_q, rd_size_d;
    logic [199:0] rd_mat_q, rd_mat_d;
    logic [2:0]   opcode_q, opcode_d;
    logic [7:0]   tamanho_q, tamanho_d;
    logic [199:0] mat_a_q, mat_a_d;
    logic [199:0] mat_b_q, mat_b_d;
    logic [199:0] result_q, result_d;
    logic         error_q, error_d;
`ifdef SEQ_TIMEOUT_EN
    logic [7:0]   tmo_q, tmo_d;
`endif

    logic unused_rdata;
    assign unused_rdata = ^{bus.mem_rdata[223:216], bus.mem_rdata[7:3]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            lat_q     <= '0;
            rd_op_q   <= '0;
            rd_size_q <= '0;
            rd_mat_q  <= '0;
            opcode_q  <= '0;
            tamanho_q <= '0;
            mat_a_q   <= '0;
            mat_b_q   <= '0;
            result_q  <= '0;
            error_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            lat_q     <= lat_d;
            rd_op_q   <= rd_op_d;
            rd_size_q <= rd_size_d;
            rd_mat_q  <= rd_mat_d;
            opcode_q  <= opcode_d;
            tamanho_q <= tamanho_d;
            mat_a_q   <= mat_a_d;
            mat_b_q   <= mat_b_d;
            result_q  <= result_d;
            error_q   <= error_d;
`ifdef SEQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        lat_d     = lat_q;
        rd_op_d   = rd_op_q;
        rd_size_d = rd_size_q;
        rd_mat_d  = rd_mat_q;
        opcode_d  = opcode_q;
        tamanho_d = tamanho_q;
        mat_a_d   = mat_a_q;
        mat_b_d   = mat_b_q;
        result_d  = result_q;
        error_d   = error_q;
`ifdef SEQ_TIMEOUT_EN
        tmo_d     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    error_d = 1'b0;
                    lat_d   = '0;
                    state_d = RD_A;
                end
            end
            // Address is held for MEM_LATENCY+1 cycles; data is taken on the exit edge.
            RD_A, RD_B: begin
                if (lat_q == 2'(MEM_LATENCY)) begin
                    rd_op_d   = bus.mem_rdata[2:0];
                    rd_size_d = bus.mem_rdata[15:8];
                    rd_mat_d  = bus.mem_rdata[215:16];
                    lat_d     = '0;
                    state_d   = (state_q == RD_A) ? LD_A : LD_B;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            LD_A: begin
                opcode_d  = rd_op_q;
                tamanho_d = rd_size_q;
                mat_a_d   = rd_mat_q;
                if (rd_op_q == 3'd7 || rd_size_q < 8'd2 || rd_size_q > 8'd5) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RD_B;
                end
            end
            LD_B: begin
                mat_b_d = rd_mat_q;
                state_d = EXEC;
            end
            EXEC: state_d = WAIT_EXEC;
            WAIT_EXEC: begin
                if (bus.exec_done) begin
                    result_d = bus.exec_result;
                    state_d  = WRITE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.mem_addr   = (state_q == RD_A)  ? base_q :
                            (state_q == RD_B)  ? base_q + 3'd1 :
                            (state_q == WRITE) ? base_q + 3'd2 : 3'd0;
    assign bus.mem_wdata  = result_q;
    assign bus.exec_start = (state_q == EXEC);
    assign bus.opcode     = opcode_q;
    assign bus.tamanho    = tamanho_q;
    assign bus.matrix_a   = mat_a_q;
    assign bus.matrix_b   = mat_b_q;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign error     = error_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_coproc_sequencer.sv
// Directed bench for coproc_sequencer: memory model with one-cycle read
// latency, inline execute responder, per-scenario check tasks.
module tb_coproc_sequencer;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [2:0] base_addr;
    logic       busy, done, error;
    logic [3:0] state_dbg;
    logic       exec_done_r;
    logic [199:0] exec_result_r;

    int checks = 0;
    int errors = 0;

    coproc_sequencer_if bus ();

    coproc_sequencer #(.MEM_LATENCY(1), .TIMEOUT_CYCLES(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // memory model: one registered address stage gives one cycle of read latency
    logic [223:0] mem [8];
    logic [2:0]   rd_addr_q;
    always @(posedge clock) rd_addr_q <= bus.mem_addr;
    assign bus.mem_rdata   = mem[rd_addr_q];
    assign bus.exec_done   = exec_done_r;
    assign bus.exec_result = exec_result_r;

    localparam logic [199:0] MA0 = 200'hA5A5_0000_1111_2222;
    localparam logic [199:0] MB1 = 200'h0BAD_CAFE_F00D;
    localparam logic [199:0] MA3 = 200'h3333_0303;
    localparam logic [199:0] MB4 = 200'h4444_4444;
    localparam logic [199:0] MA6 = 200'h6666;
    localparam logic [199:0] MA7 = 200'h7777_0007;

    function automatic logic [223:0] slot(input logic [2:0] op, input logic [7:0] sz,
                                          input logic [199:0] mat);
        return {8'h00, mat, sz, 5'b0, op};
    endfunction

    // monitor, sampled on the falling edge
    int           we_cnt = 0, done_cnt = 0, xs_cnt = 0, wait_cnt = 0;
    logic [2:0]   we_addr = '0, rd_last = '0, rd_prev = '0;
    logic [199:0] we_data = '0;
    logic [3:0]   prev_state = '0;
    always @(negedge clock) begin
        if (bus.mem_we) begin
            we_cnt++;
            we_addr = bus.mem_addr;
            we_data = bus.mem_wdata;
        end
        if (done) done_cnt++;
        if (bus.exec_start) xs_cnt++;
        if (state_dbg == 4'd6) wait_cnt++;
        if ((state_dbg == 4'd1 || state_dbg == 4'd3) && state_dbg != prev_state) begin
            rd_prev = rd_last;
            rd_last = bus.mem_addr;
        end
        prev_state = state_dbg;
    end

    // driver: start an operation and run until done (stop_state 15) or until stop_state
    task automatic run_op(input logic [2:0] base, input int dly, input logic [199:0] res,
                          input bit respond, input logic [3:0] stop_state,
                          input string name, output int xs_cycle);
        int  cd;
        bit  ok;
        cd = -1;
        ok = 1'b0;
        xs_cycle = -1;
        @(negedge clock);
        start = 1'b1;
        base_addr = base;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            if (c == 1) begin
                start = 1'b0;
                base_addr = 3'd0;
            end
            exec_done_r = 1'b0;
            if (bus.exec_start && xs_cycle < 0) begin
                xs_cycle = c;
                cd = dly;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0 && respond) begin
                    exec_done_r = 1'b1;
                    exec_result_r = res;
                end
            end
            if (stop_state != 4'd15 && state_dbg == stop_state) begin
                ok = 1'b1;
                break;
            end
            if (stop_state == 4'd15 && done) begin
                ok = 1'b1;
                @(negedge clock);
                #1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            $display("FAIL %s_bound: got no completion, required completion within 200 cycles", name);
            errors++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = 3'd0;
        exec_done_r = 1'b0;
        exec_result_r = '0;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (state_dbg !== 4'd0) begin $display("FAIL rst_state: got %0d required 0", state_dbg); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b required 0", busy); errors++; end
        checks++; if (done !== 1'b0) begin $display("FAIL rst_done: got %b required 0", done); errors++; end
        checks++; if (error !== 1'b0) begin $display("FAIL rst_error: got %b required 0", error); errors++; end
        checks++; if (bus.mem_we !== 1'b0) begin $display("FAIL rst_we: got %b required 0", bus.mem_we); errors++; end
        checks++; if (bus.exec_start !== 1'b0) begin $display("FAIL rst_xs: got %b required 0", bus.exec_start); errors++; end
        checks++; if (bus.mem_addr !== 3'd0) begin $display("FAIL rst_addr: got %0d required 0", bus.mem_addr); errors++; end
        checks++; if (bus.opcode !== 3'd0 || bus.tamanho !== 8'd0) begin $display("FAIL rst_opsz: got %0d/%0d required 0/0", bus.opcode, bus.tamanho); errors++; end
        checks++; if (bus.matrix_a !== 200'd0 || bus.mem_wdata !== 200'd0) begin $display("FAIL rst_data: got %0h/%0h required 0/0", bus.matrix_a, bus.mem_wdata); errors++; end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int we0, dn0, xs0, xc;
        we0 = we_cnt; dn0 = done_cnt; xs0 = xs_cnt;
        run_op(3'd0, 4, 200'h1234, 1'b1, 4'd15, "basic", xc);
        checks++; if (xc !== 7) begin $display("FAIL basic_xs_latency: got %0d required 7", xc); errors++; end
        checks++; if (we_cnt - we0 !== 1) begin $display("FAIL basic_we_count: got %0d required 1", we_cnt - we0); errors++; end
        checks++; if (we_addr !== 3'd2) begin $display("FAIL basic_we_addr: got %0d required 2", we_addr); errors++; end
        checks++; if (we_data !== 200'h1234) begin $display("FAIL basic_we_data: got %0h required 1234", we_data); errors++; end
        checks++; if (done_cnt - dn0 !== 1) begin $display("FAIL basic_done: got %0d required 1", done_cnt - dn0); errors++; end
        checks++; if (xs_cnt - xs0 !== 1) begin $display("FAIL basic_xs_count: got %0d required 1", xs_cnt - xs0); errors++; end
        checks++; if (busy !== 1'b0 || error !== 1'b0) begin $display("FAIL basic_busy_err: got %b/%b required 0/0", busy, error); errors++; end
        checks++; if (bus.opcode !== 3'd1 || bus.tamanho !== 8'd3) begin $display("FAIL basic_opsz: got %0d/%0d required 1/3", bus.opcode, bus.tamanho); errors++; end
        checks++; if (bus.matrix_a !== MA0) begin $display("FAIL basic_mat_a: got %0h required %0h", bus.matrix_a, MA0); errors++; end
        checks++; if (bus.matrix_b !== MB1) begin $display("FAIL basic_mat_b: got %0h required %0h", bus.matrix_b, MB1); errors++; end
        checks++; if (rd_prev !== 3'd0 || rd_last !== 3'd1) begin $display("FAIL basic_rd_addr: got %0d,%0d required 0,1", rd_prev, rd_last); errors++; end
    endtask

    task automatic test_wrap();
        int we0, xc;
        we0 = we_cnt;
        run_op(3'd7, 2, 200'hBEEF, 1'b1, 4'd15, "wrap", xc);
        checks++; if (rd_prev !== 3'd7 || rd_last !== 3'd0) begin $display("FAIL wrap_rd_addr: got %0d,%0d required 7,0", rd_prev, rd_last); errors++; end
        checks++; if (we_cnt - we0 !== 1 || we_addr !== 3'd1) begin $display("FAIL wrap_we: got cnt %0d addr %0d required cnt 1 addr 1", we_cnt - we0, we_addr); errors++; end
        checks++; if (we_data !== 200'hBEEF) begin $display("FAIL wrap_we_data: got %0h required beef", we_data); errors++; end
        checks++; if (bus.opcode !== 3'd3 || bus.tamanho !== 8'd5) begin $display("FAIL wrap_opsz: got %0d/%0d required 3/5", bus.opcode, bus.tamanho); errors++; end
        checks++; if (bus.matrix_a !== MA7 || bus.matrix_b !== MA0) begin $display("FAIL wrap_mats: got %0h/%0h required %0h/%0h", bus.matrix_a, bus.matrix_b, MA7, MA0); errors++; end
    endtask

    task automatic test_bad_slot();
        int we0, dn0, xs0, xc;
        we0 = we_cnt; dn0 = done_cnt; xs0 = xs_cnt;
        run_op(3'd4, 4, 200'h1, 1'b1, 4'd15, "bad_op", xc);
        checks++; if (error !== 1'b1) begin $display("FAIL bad_op_error: got %b required 1", error); errors++; end
        checks++; if (done_cnt - dn0 !== 1) begin $display("FAIL bad_op_done: got %0d required 1", done_cnt - dn0); errors++; end
        checks++; if (xs_cnt - xs0 !== 0 || we_cnt - we0 !== 0) begin $display("FAIL bad_op_quiet: got xs %0d we %0d required 0 0", xs_cnt - xs0, we_cnt - we0); errors++; end
        checks++; if (bus.matrix_b !== MA0) begin $display("FAIL bad_op_hold_b: got %0h required %0h", bus.matrix_b, MA0); errors++; end
        checks++; if (bus.opcode !== 3'd7) begin $display("FAIL bad_op_opcode: got %0d required 7", bus.opcode); errors++; end
        we0 = we_cnt; dn0 = done_cnt; xs0 = xs_cnt;
        run_op(3'd6, 4, 200'h1, 1'b1, 4'd15, "bad_size", xc);
        checks++; if (error !== 1'b1 || done_cnt - dn0 !== 1) begin $display("FAIL bad_size_err_done: got %b/%0d required 1/1", error, done_cnt - dn0); errors++; end
        checks++; if (xs_cnt - xs0 !== 0 || we_cnt - we0 !== 0) begin $display("FAIL bad_size_quiet: got xs %0d we %0d required 0 0", xs_cnt - xs0, we_cnt - we0); errors++; end
        checks++; if (bus.tamanho !== 8'd9 || rd_last !== 3'd6) begin $display("FAIL bad_size_load: got %0d rd %0d required 9 rd 6", bus.tamanho, rd_last); errors++; end
    endtask

    task automatic test_ignored();
        int we0, xc;
        we0 = we_cnt;
        run_op(3'd3, 4, 200'h0, 1'b0, 4'd6, "ign_reach", xc);
        checks++; if (error !== 1'b0) begin $display("FAIL ign_error_cleared: got %b required 0", error); errors++; end
        @(negedge clock); start = 1'b1; base_addr = 3'd5;
        @(negedge clock); start = 1'b0; base_addr = 3'd0;
        @(negedge clock);
        checks++; if (state_dbg !== 4'd6) begin $display("FAIL ign_start_in_wait: got state %0d required 6", state_dbg); errors++; end
        exec_done_r = 1'b1; exec_result_r = 200'h55;
        @(negedge clock); exec_done_r = 1'b0;
        checks++; if (state_dbg !== 4'd7 || bus.mem_addr !== 3'd5) begin $display("FAIL ign_write: got state %0d addr %0d required 7 addr 5", state_dbg, bus.mem_addr); errors++; end
        repeat (3) @(negedge clock);
        checks++; if (we_cnt - we0 !== 1 || we_data !== 200'h55) begin $display("FAIL ign_we: got cnt %0d data %0h required 1 55", we_cnt - we0, we_data); errors++; end
        checks++; if (bus.opcode !== 3'd2 || bus.matrix_a !== MA3 || bus.matrix_b !== MB4) begin $display("FAIL ign_operands: got op %0d a %0h b %0h", bus.opcode, bus.matrix_a, bus.matrix_b); errors++; end
        exec_done_r = 1'b1; exec_result_r = 200'h99;
        @(negedge clock); exec_done_r = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (state_dbg !== 4'd0 || busy !== 1'b0) begin $display("FAIL ign_done_in_idle: got state %0d busy %b required 0 0", state_dbg, busy); errors++; end
        checks++; if (we_cnt - we0 !== 1) begin $display("FAIL ign_no_extra_we: got %0d required 1", we_cnt - we0); errors++; end
    endtask

    task automatic test_reset_abort();
        int we0, xc;
        we0 = we_cnt;
        run_op(3'd0, 4, 200'h0, 1'b0, 4'd6, "abort_reach", xc);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || bus.mem_we !== 1'b0) begin $display("FAIL abort_immediate: got busy %b we %b required 0 0", busy, bus.mem_we); errors++; end
        checks++; if (state_dbg !== 4'd0 || bus.opcode !== 3'd0) begin $display("FAIL abort_regs: got state %0d opcode %0d required 0 0", state_dbg, bus.opcode); errors++; end
        @(negedge clock); exec_done_r = 1'b1; exec_result_r = 200'hDEAD;
        @(negedge clock); exec_done_r = 1'b0; reset_n = 1'b1;
        @(negedge clock); exec_done_r = 1'b1;
        @(negedge clock); exec_done_r = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (we_cnt - we0 !== 0 || state_dbg !== 4'd0) begin $display("FAIL abort_no_write: got we %0d state %0d required 0 0", we_cnt - we0, state_dbg); errors++; end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int we0, dn0, wt0, xc;
        we0 = we_cnt; dn0 = done_cnt; wt0 = wait_cnt;
        run_op(3'd0, 4, 200'h0, 1'b0, 4'd15, "tmo", xc);
        checks++; if (error !== 1'b1 || done_cnt - dn0 !== 1) begin $display("FAIL tmo_err_done: got %b/%0d required 1/1", error, done_cnt - dn0); errors++; end
        checks++; if (wait_cnt - wt0 !== 16) begin $display("FAIL tmo_wait_cycles: got %0d required 16", wait_cnt - wt0); errors++; end
        checks++; if (we_cnt - we0 !== 0) begin $display("FAIL tmo_no_we: got %0d required 0", we_cnt - we0); errors++; end
        run_op(3'd0, 3, 200'h77, 1'b1, 4'd15, "tmo_recover", xc);
        checks++; if (error !== 1'b0 || we_cnt - we0 !== 1) begin $display("FAIL tmo_recover: got err %b we %0d required 0 1", error, we_cnt - we0); errors++; end
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[0] = slot(3'd1, 8'd3, MA0);
        mem[1] = slot(3'd0, 8'd0, MB1);
        mem[3] = slot(3'd2, 8'd2, MA3);
        mem[4] = slot(3'd7, 8'd3, MB4);
        mem[6] = slot(3'd1, 8'd9, MA6);
        mem[7] = slot(3'd3, 8'd5, MA7);
        test_reset();
        test_basic();
        test_wrap();
        test_bad_slot();
        test_ignored();
        test_reset_abort();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
